axi_read_arbiter: RTL and testbench
===================================

// Module: axi_read_arbiter
// PURPOSE
//  Shares the single AXI3 read channel (AR/R) between the I-cache refill controller (port I) and the
//  D-cache refill controller (port D). Grants one burst at a time with round-robin fairness, drives AR,
//  tags bursts with ARID, and steers R beats to the owning requester. Sits between the cache controllers
//  and the memory interface, above both IF and MEM.
// PARAMETERS
//  ADDR_W  32  address width (ARADDR, i_addr, d_addr)
//  DATA_W  32  R data width; ARSIZE = log2(DATA_W/8)
//  LEN_W   4   AXI3 ARLEN width; a burst is len+1 beats (1..16)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       reset, asynchronous, active-low
//  flush      in   1       IF flush; cancels delivery of any in-flight port I burst
//  i_req      in   1       port I burst request; held until i_gnt
//  i_addr     in   ADDR_W  port I burst start address (line aligned)
//  i_len      in   LEN_W   port I ARLEN (beats-1)
//  i_gnt      out  1       1-cycle pulse: port I request accepted on AR
//  i_rdata    out  DATA_W  beat data to port I
//  i_rvalid   out  1       beat valid to port I
//  i_rlast    out  1       last beat of port I burst
//  d_req/d_addr/d_len/d_gnt/d_rdata/d_rvalid/d_rlast  same as port I, for port D
//  err        out  1       1-cycle pulse: protocol violation on R (see BEHAVIOUR)
//  ARADDR     out  ADDR_W  AXI read address
//  ARLEN      out  LEN_W   AXI burst length
//  ARSIZE     out  3       constant log2(DATA_W/8)
//  ARBURST    out  2       constant INCR (2'b01)
//  ARID       out  1       0 = port I, 1 = port D
//  ARVALID    out  1       AXI address valid
//  ARREADY    in   1       AXI address ready
//  RDATA      in   DATA_W  AXI read data
//  RID        in   1       AXI read ID
//  RRESP      in   2       AXI read response (forwarded errors: SLVERR/DECERR raise err)
//  RLAST      in   1       AXI last beat
//  RVALID     in   1       AXI read valid
//  RREADY     out  1       AXI read ready
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, ARVALID=0, RREADY=0, i_gnt=d_gnt=0, err=0, rr_ptr=I, drop=0,
//   beat_cnt=0; ARADDR/ARLEN/ARID=0. Outstanding AXI transaction is abandoned (slave reset together).
//  One outstanding burst max. States: IDLE -> ADDR -> DATA -> IDLE.
//  IDLE: if i_req|d_req, pick winner: both requesting -> rr_ptr side; else the requester. Latch addr,
//   len, owner into ARADDR/ARLEN/ARID; -> ADDR. ARVALID rises the cycle after req is seen.
//   flush=1 in IDLE masks i_req for that cycle.
//  ADDR: ARVALID=1, AR fields stable. On ARVALID&ARREADY: owner gnt pulses that cycle, -> DATA,
//   beat_cnt=0. Requester deasserting req after latch does not cancel the burst.
//  DATA: RREADY=1 (requesters must accept every beat, no backpressure). Beat routed combinationally:
//   x_rvalid = RVALID & (owner==x) & (RID==owner) & !(owner==I & drop); x_rdata=RDATA; x_rlast=RLAST.
//   beat_cnt increments per RVALID. On RVALID&RLAST -> IDLE, rr_ptr = other side of owner.
//  Errors (err pulse, beat still consumed): RID!=owner (beat dropped); RLAST with beat_cnt!=ARLEN;
//   beat_cnt==ARLEN without RLAST (beat dropped from count, wait for RLAST); RRESP[1]=1.
//  flush while owner==I in ADDR or DATA: drop=1; AR still completes (i_gnt still pulses), all remaining
//   I beats drained with RREADY=1 but i_rvalid/i_rlast held 0; drop clears on return to IDLE.
//   flush with owner==D: no effect.
//  Latency: idle req at N -> ARVALID N+1 -> earliest gnt N+1 -> earliest beat N+2; zero-cycle R routing.
//  Back-to-back: after RLAST, IDLE arbitrates next cycle (one bubble cycle between bursts).
// STRUCTURE
//  Shared include axi_defs.vh: AXI_BURST_INCR, AXI_RESP_* codes, OWNER_I/OWNER_D IDs, FSM state codes
//   (IDLE/ADDR/DATA). Sub-module rr_arbiter2 (2-way round-robin pick + pointer update) is natural;
//   FSM, beat counter, drop flag and R steering stay in axi_read_arbiter.
// TESTING
//  1. i_req, addr=0x100, len=3; ARREADY=1 -> ARVALID next cycle, ARID=0, i_gnt 1 cycle, 4 beats on i_*, i_rlast on 4th.
//  2. i_req & d_req same cycle after reset -> I served first; D ARVALID one cycle after I's RLAST; then both again -> D first.
//  3. ARREADY held 0 for 5 cycles -> ARADDR/ARLEN/ARID stable, ARVALID=1 throughout, no gnt until ARREADY.
//  4. flush mid I burst (beat 2 of 8) -> beats 3..8 drained, i_rvalid=0 for them, d_* untouched, next req served.
//  5. RLAST at beat 2 of len=3 burst -> err pulse, FSM to IDLE; RID=1 during I burst -> err, beat not delivered.
//  6. rst low mid DATA -> ARVALID/RREADY/gnts 0 immediately, state IDLE, rr_ptr=I after release.

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
// Shared AXI constants, owner IDs and FSM state encoding for the read-channel arbiter.
// Imported by the arbiter top and its round-robin sub-module.
package axi_read_arbiter_pkg;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // The owner value doubles as the ARID/RID tag on the bus.
   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   function automatic owner_e other_owner(input owner_e o);
      return (o == OWNER_I) ? OWNER_D : OWNER_I;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between port I and port D.
// The pointer moves to the side opposite the owner once that owner's burst completes.
module rr_arbiter2
   import axi_read_arbiter_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   i_req,
   input  logic   d_req,
   input  logic   update,
   input  owner_e last_owner,
   output logic   valid,
   output owner_e winner
);

   owner_e rr_ptr;

   // NOTE: every output gets a default before the branches, so no latch is inferred.
   always_comb begin
      valid  = i_req | d_req;
      winner = rr_ptr;
      if (i_req && !d_req)
         winner = OWNER_I;
      else if (d_req && !i_req)
         winner = OWNER_D;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rr_ptr <= OWNER_I;
      else if (update)
         rr_ptr <= other_owner(last_owner);
   end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI3 read channel between the I-cache and D-cache refill controllers:
// one outstanding burst, round-robin grant, ARID tagging, and zero-cycle R steering with flush drop.
module axi_read_arbiter
   import axi_read_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [LEN_W-1:0]  i_len,
   output logic              i_gnt,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_rvalid,
   output logic              i_rlast,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LEN_W-1:0]  d_len,
   output logic              d_gnt,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_rvalid,
   output logic              d_rlast,
   output logic              err,
   output logic [ADDR_W-1:0] ARADDR,
   output logic [LEN_W-1:0]  ARLEN,
   output logic [2:0]        ARSIZE,
   output logic [1:0]        ARBURST,
   output logic              ARID,
   output logic              ARVALID,
   input  logic              ARREADY,
   input  logic [DATA_W-1:0] RDATA,
   input  logic              RID,
   input  logic [1:0]        RRESP,
   input  logic              RLAST,
   input  logic              RVALID,
   output logic              RREADY
);

   state_e           state_q, state_d;
   owner_e           owner_q;
   logic [LEN_W-1:0] beat_cnt_q;
   logic             drop_q;

   logic   arb_valid;
   owner_e arb_winner;

   logic ar_fire, r_beat, burst_end, id_ok, at_len, resp_err;

   // An IF flush in IDLE hides the I request for that cycle only.
   rr_arbiter2 u_rr (
      .clk        (clk),
      .rst        (rst),
      .i_req      (i_req & ~flush),
      .d_req      (d_req),
      .update     (burst_end),
      .last_owner (owner_q),
      .valid      (arb_valid),
      .winner     (arb_winner)
   );

   assign ar_fire   = (state_q == ST_ADDR) & ARREADY;
   assign r_beat    = (state_q == ST_DATA) & RVALID;
   assign burst_end = r_beat & RLAST;
   assign id_ok     = (RID == owner_q);
   assign at_len    = (beat_cnt_q == ARLEN);
   assign resp_err  = (RRESP == AXI_RESP_SLVERR) | (RRESP == AXI_RESP_DECERR);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (arb_valid) state_d = ST_ADDR;
         ST_ADDR: if (ARREADY)   state_d = ST_DATA;
         ST_DATA: if (RVALID && RLAST) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign ARVALID = (state_q == ST_ADDR);
   assign RREADY  = (state_q == ST_DATA);
   assign ARID    = (owner_q == OWNER_D);
   assign ARSIZE  = 3'($clog2(DATA_W / 8));
   assign ARBURST = AXI_BURST_INCR;

   assign i_gnt = ar_fire & (owner_q == OWNER_I);
   assign d_gnt = ar_fire & (owner_q == OWNER_D);

   // Beats are steered straight through; a flushed I burst is drained silently.
   assign i_rvalid = r_beat & (owner_q == OWNER_I) & id_ok & ~drop_q;
   assign d_rvalid = r_beat & (owner_q == OWNER_D) & id_ok;
   assign i_rlast  = i_rvalid & RLAST;
   assign d_rlast  = d_rvalid & RLAST;
   assign i_rdata  = RDATA;
   assign d_rdata  = RDATA;

   assign err = r_beat & (~id_ok | (RLAST & ~at_len) | (at_len & ~RLAST) | resp_err);

   // NOTE: only control and AR fields carry reset; the datapath is pure wiring, so no storage is left unreset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWNER_I;
         ARADDR     <= '0;
         ARLEN      <= '0;
         beat_cnt_q <= '0;
         drop_q     <= 1'b0;
      end else begin
         state_q <= state_d;

         if (state_q == ST_IDLE && arb_valid) begin
            owner_q <= arb_winner;
            ARADDR  <= (arb_winner == OWNER_I) ? i_addr : d_addr;
            ARLEN   <= (arb_winner == OWNER_I) ? i_len  : d_len;
         end

         // Wrong-ID beats and overrun beats past ARLEN do not advance the count.
         if (ar_fire)
            beat_cnt_q <= '0;
         else if (r_beat && id_ok && !(at_len && !RLAST))
            beat_cnt_q <= beat_cnt_q + LEN_W'(1);

         if (state_d == ST_IDLE)
            drop_q <= 1'b0;
         else if (flush && state_q != ST_IDLE && owner_q == OWNER_I)
            drop_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: latency, round-robin order, AR stall, flush drain,
// R protocol errors and mid-burst reset, each against hand-computed values.
module tb_axi_read_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              i_req, d_req;
   logic [ADDR_W-1:0] i_addr, d_addr;
   logic [LEN_W-1:0]  i_len, d_len;
   logic              i_gnt, d_gnt, i_rvalid, d_rvalid, i_rlast, d_rlast, err;
   logic [DATA_W-1:0] i_rdata, d_rdata;
   logic [ADDR_W-1:0] ARADDR;
   logic [LEN_W-1:0]  ARLEN;
   logic [2:0]        ARSIZE;
   logic [1:0]        ARBURST;
   logic              ARID, ARVALID, ARREADY;
   logic [DATA_W-1:0] RDATA;
   logic              RID, RLAST, RVALID, RREADY;
   logic [1:0]        RRESP;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   axi_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_gnt(i_gnt),
      .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
      .d_req(d_req), .d_addr(d_addr), .d_len(d_len), .d_gnt(d_gnt),
      .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
      .err(err),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARID(ARID), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RID(RID), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
      .RREADY(RREADY)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Drives one R beat for a cycle (inputs change just after the falling edge), checks routing, returns at the next falling edge.
   task automatic beat(input string tag, input logic id, input logic [DATA_W-1:0] data,
                       input logic last, input logic [1:0] resp,
                       input logic exp_i, input logic exp_d, input logic exp_err);
      RVALID = 1'b1; RID = id; RDATA = data; RLAST = last; RRESP = resp;
      #1;
      check({tag, "_rready"}, RREADY, 1'b1);
      check({tag, "_i_rvalid"}, i_rvalid, exp_i);
      check({tag, "_d_rvalid"}, d_rvalid, exp_d);
      check({tag, "_err"}, err, exp_err);
      if (exp_i) begin
         check({tag, "_i_rdata"}, i_rdata, data);
         check({tag, "_i_rlast"}, i_rlast, last);
      end
      if (exp_d) begin
         check({tag, "_d_rdata"}, d_rdata, data);
         check({tag, "_d_rlast"}, d_rlast, last);
      end
      @(negedge clk);
      RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
   endtask

   // Single-cycle AR handshake check on the falling edge after the request was seen.
   task automatic expect_ar(input string tag, input logic [ADDR_W-1:0] addr,
                            input logic [LEN_W-1:0] len, input logic id);
      @(negedge clk); #1;
      check({tag, "_arvalid"}, ARVALID, 1'b1);
      check({tag, "_araddr"}, ARADDR, addr);
      check({tag, "_arlen"}, ARLEN, len);
      check({tag, "_arid"}, ARID, id);
      check({tag, "_i_gnt"}, i_gnt, !id);
      check({tag, "_d_gnt"}, d_gnt, id);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; flush = 1'b0;
      i_req = 1'b0; i_addr = '0; i_len = '0;
      d_req = 1'b0; d_addr = '0; d_len = '0;
      ARREADY = 1'b0; RDATA = '0; RID = 1'b0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;

      // Reset state
      @(negedge clk); #1;
      check("rst_arvalid", ARVALID, 1'b0);
      check("rst_rready", RREADY, 1'b0);
      check("rst_i_gnt", i_gnt, 1'b0);
      check("rst_d_gnt", d_gnt, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_araddr", ARADDR, 32'h0);
      check("rst_arlen", ARLEN, 4'h0);
      check("rst_arid", ARID, 1'b0);
      check("rst_arsize", ARSIZE, 3'd2);
      check("rst_arburst", ARBURST, 2'b01);
      @(negedge clk); rst = 1'b1;

      // 1: single I burst, len=3
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h100; i_len = 4'd3; ARREADY = 1'b1;
      #1 check("t1_arvalid_n", ARVALID, 1'b0);
      expect_ar("t1", 32'h100, 4'd3, 1'b0);
      i_req = 1'b0;
      @(negedge clk); #1;
      check("t1_gnt_once", i_gnt, 1'b0);
      beat("t1_b0", 1'b0, 32'hA000_0000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      beat("t1_b1", 1'b0, 32'hA000_0001, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      beat("t1_b2", 1'b0, 32'hA000_0002, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      beat("t1_b3", 1'b0, 32'hA000_0003, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
      #1 check("t1_idle_rready", RREADY, 1'b0);

      // 2: simultaneous requests after reset -> I first, then D wins while I re-requests
      rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      i_req = 1'b1; i_addr = 32'h200; i_len = 4'd0;
      d_req = 1'b1; d_addr = 32'h300; d_len = 4'd0;
      #1 check("t2_arvalid_n", ARVALID, 1'b0);
      expect_ar("t2_i", 32'h200, 4'd0, 1'b0);
      i_req = 1'b0;
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h400; i_len = 4'd7;
      beat("t2_ib", 1'b0, 32'hB000_0000, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
      #1 check("t2_bubble", ARVALID, 1'b0);
      expect_ar("t2_d", 32'h300, 4'd0, 1'b1);
      d_req = 1'b0;
      @(negedge clk); ARREADY = 1'b0;
      beat("t2_db", 1'b1, 32'hC000_0000, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
      #1 check("t3_bubble", ARVALID, 1'b0);

      // 3: AR stalled for 5 cycles
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         check("t3_arvalid", ARVALID, 1'b1);
         check("t3_araddr", ARADDR, 32'h400);
         check("t3_arlen", ARLEN, 4'd7);
         check("t3_arid", ARID, 1'b0);
         check("t3_no_gnt", i_gnt, 1'b0);
      end
      @(negedge clk); ARREADY = 1'b1;
      #1 check("t3_gnt", i_gnt, 1'b1);
      i_req = 1'b0;

      // 4: flush after beat 2 of 8 -> beats 3..8 drained silently
      @(negedge clk);
      beat("t4_b1", 1'b0, 32'hD000_0001, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      beat("t4_b2", 1'b0, 32'hD000_0002, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      for (int k = 3; k < 8; k++)
         beat("t4_drain", 1'b0, 32'hD000_0000 + k, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      beat("t4_b8", 1'b0, 32'hD000_0008, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
      // flush in IDLE masks i_req for that cycle
      i_req = 1'b1; i_addr = 32'h500; i_len = 4'd0; flush = 1'b1;
      #1 check("t4_mask0", ARVALID, 1'b0);
      @(negedge clk); flush = 1'b0;
      #1 check("t4_mask1", ARVALID, 1'b0);
      expect_ar("t4_next", 32'h500, 4'd0, 1'b0);
      i_req = 1'b0;
      @(negedge clk);
      beat("t4_nb", 1'b0, 32'hE000_0000, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);

      // 5: SLVERR beat, early RLAST, wrong RID, overrun past ARLEN
      i_req = 1'b1; i_addr = 32'h600; i_len = 4'd3;
      expect_ar("t5a", 32'h600, 4'd3, 1'b0);
      i_req = 1'b0;
      @(negedge clk);
      beat("t5_slverr", 1'b0, 32'h5000_0000, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1);
      beat("t5_ok", 1'b0, 32'h5000_0001, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      beat("t5_early", 1'b0, 32'h5000_0002, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
      #1 check("t5_idle_rready", RREADY, 1'b0);
      i_req = 1'b1; i_addr = 32'h700; i_len = 4'd1;
      expect_ar("t5b", 32'h700, 4'd1, 1'b0);
      i_req = 1'b0;
      @(negedge clk);
      beat("t5_badid", 1'b1, 32'h6000_0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
      beat("t5_b0", 1'b0, 32'h6000_0001, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      beat("t5_b1", 1'b0, 32'h6000_0002, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
      i_req = 1'b1; i_addr = 32'h800; i_len = 4'd0;
      expect_ar("t5c", 32'h800, 4'd0, 1'b0);
      i_req = 1'b0;
      @(negedge clk);
      beat("t5_overrun", 1'b0, 32'h7000_0000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
      beat("t5_last", 1'b0, 32'h7000_0001, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);

      // 6: reset in the middle of a D burst
      d_req = 1'b1; d_addr = 32'h900; d_len = 4'd3;
      expect_ar("t6", 32'h900, 4'd3, 1'b1);
      d_req = 1'b0;
      @(negedge clk);
      beat("t6_b0", 1'b1, 32'h9000_0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      RVALID = 1'b1; RID = 1'b1; RDATA = 32'h9000_0001;
      rst = 1'b0;
      #1;
      check("t6_arvalid", ARVALID, 1'b0);
      check("t6_rready", RREADY, 1'b0);
      check("t6_d_rvalid", d_rvalid, 1'b0);
      check("t6_d_gnt", d_gnt, 1'b0);
      check("t6_err", err, 1'b0);
      check("t6_araddr", ARADDR, 32'h0);
      check("t6_arid", ARID, 1'b0);
      RVALID = 1'b0;
      @(negedge clk); rst = 1'b1;
      i_req = 1'b1; i_addr = 32'hA00; i_len = 4'd0;
      d_req = 1'b1; d_addr = 32'hB00; d_len = 4'd0;
      expect_ar("t6_rr", 32'hA00, 4'd0, 1'b0);
      i_req = 1'b0; d_req = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
